cell_vector_sequencer: RTL and testbench

Exhaustive truth-table checker for the single-output combinational library cells (INVX1 through AOI22X1 class, 1–4 inputs). It sits directly upstream of a cell-under-test, driving its inputs with every binary vector in ascending order. It also consumes the cell's Y output, comparing each sample against a caller-supplied expected truth table. It reports the mismatch count and the index of the first failing vector, and is used in the characterization bench and in per-cell logic regression.

---
 rtl/cellchk_pkg.sv | 6 +
 rtl/cell_vector_sequencer_if.sv | 13 +
 rtl/cell_vector_sequencer_settle_timer.sv | 19 +
 rtl/cell_vector_sequencer.sv | 67 ++++++
 tb/tb_cell_vector_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/cellchk_pkg.sv
// cellchk_pkg: shared types and widths for the cell truth-table sequencer
package cellchk_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  localparam int N_MAX = 4;
  localparam int TMR_W = 4;
endpackage

// File: rtl/cell_vector_sequencer_if.sv
// cell_vector_sequencer_if: control, cell-drive and result signals of the sequencer
interface cell_vector_sequencer_if #(parameter int N_IN = 2);
  logic                 START;
  logic [2**N_IN-1:0]   TT;
  logic [N_IN-1:0]      VEC;
  logic                 Y;
  logic                 BUSY;
  logic                 DONE;
  logic [N_IN:0]        ERRCNT;
  logic [N_IN-1:0]      FIRSTERR;
  modport master(input START, TT, Y, output VEC, BUSY, DONE, ERRCNT, FIRSTERR);
  modport slave(output START, TT, Y, input VEC, BUSY, DONE, ERRCNT, FIRSTERR);
endinterface

// File: rtl/cell_vector_sequencer_settle_timer.sv
// settle_timer: loadable down-counter flagging when the settle window has elapsed
module settle_timer
  import cellchk_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [TMR_W-1:0] i_val,
  output logic             o_zero
);
  logic [TMR_W-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/cell_vector_sequencer.sv
// cell_vector_sequencer: walks every input vector of a cell and counts Y mismatches
module cell_vector_sequencer
  import cellchk_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
)(
  input logic CLK,
  input logic R,
  cell_vector_sequencer_if.master bus
);
  localparam logic [N_IN-1:0] VMAX = '1;
  state_t             r_state, w_next;
  logic [2**N_IN-1:0] r_tt;
  logic [N_IN-1:0]    r_vec, r_firsterr;
  logic [N_IN:0]      r_errcnt;
  logic               r_busy, r_done;
  logic               w_zero, w_start, w_sample, w_last, w_mis, w_load, w_dec;
  settle_timer u_timer (
    .i_clk  (CLK),
    .i_rst_n(R),
    .i_load (w_load),
    .i_dec  (w_dec),
    .i_val  (TMR_W'(SETTLE)),
    .o_zero (w_zero)
  );
  always_ff @(posedge CLK) r_state <= !R ? IDLE : w_next;
  // case inequality so that X/Z on Y is reported as a mismatch
  always_comb begin
    w_start  = r_state == IDLE && bus.START;
    w_sample = r_state == WAIT && w_zero;
    w_last   = r_vec == VMAX;
    w_mis    = w_sample && (bus.Y !== r_tt[r_vec]);
    w_load   = w_start || (w_sample && !w_last);
    w_dec    = r_state == WAIT && !w_zero;
    w_next   = r_state == IDLE ? (bus.START ? WAIT : IDLE) : (w_sample && w_last ? IDLE : WAIT);
  end
  always_ff @(posedge CLK) begin
    if (!R) begin
      r_tt       <= '0;
      r_vec      <= '0;
      r_firsterr <= '0;
      r_errcnt   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_sample && w_last;
      if (w_start) begin
        r_tt       <= bus.TT;
        r_vec      <= '0;
        r_firsterr <= '0;
        r_errcnt   <= '0;
        r_busy     <= 1'b1;
      end else if (w_sample) begin
        if (w_mis) r_errcnt <= r_errcnt + 1'b1;
        if (w_mis && r_errcnt == '0) r_firsterr <= r_vec;
        r_vec <= w_last ? '0 : r_vec + 1'b1;
        if (w_last) r_busy <= 1'b0;
      end
    end
  end
  assign bus.VEC      = r_vec;
  assign bus.BUSY     = r_busy;
  assign bus.DONE     = r_done;
  assign bus.ERRCNT   = r_errcnt;
  assign bus.FIRSTERR = r_firsterr;
endmodule

// File: tb/tb_cell_vector_sequencer.sv
// tb_cell_vector_sequencer: three sequencer configurations driving behavioural cells, checked against a run-level model
module tb_cell_vector_sequencer;
  localparam int NN [3] = '{2, 3, 1};
  localparam int SS [3] = '{1, 0, 2};
  logic CLK = 1'b0;
  logic R = 1'b0;
  logic st [3];
  logic [15:0] tt [3];
  logic xor_mode = 1'b0;
  logic x_en = 1'b0;
  int checks = 0;
  int errors = 0;
  bit m_act [3];
  bit m_done [3];
  int m_k [3];
  int m_err [3];
  int m_first [3];
  logic [15:0] m_tt [3];
  logic [31:0] ovec [3], oerr [3], ofe [3];
  logic obusy [3], odone [3], yv [3];
  always #5 CLK = ~CLK;
  cell_vector_sequencer_if #(.N_IN(2)) b0();
  cell_vector_sequencer_if #(.N_IN(3)) b1();
  cell_vector_sequencer_if #(.N_IN(1)) b2();
  cell_vector_sequencer #(.N_IN(2), .SETTLE(1)) u0(.CLK(CLK), .R(R), .bus(b0));
  cell_vector_sequencer #(.N_IN(3), .SETTLE(0)) u1(.CLK(CLK), .R(R), .bus(b1));
  cell_vector_sequencer #(.N_IN(1), .SETTLE(2)) u2(.CLK(CLK), .R(R), .bus(b2));
  assign b0.START = st[0];
  assign b1.START = st[1];
  assign b2.START = st[2];
  assign b0.TT = tt[0][3:0];
  assign b1.TT = tt[1][7:0];
  assign b2.TT = tt[2][1:0];
  assign b0.Y = (x_en && b0.VEC == 2'd2) ? 1'bx : (xor_mode ? ^b0.VEC : ~&b0.VEC);
  assign b1.Y = ~((b1.VEC[0] & b1.VEC[1]) | b1.VEC[2]);
  assign b2.Y = ~b2.VEC[0];
  assign yv[0] = b0.Y;
  assign yv[1] = b1.Y;
  assign yv[2] = b2.Y;
  assign ovec[0] = 32'(b0.VEC);
  assign ovec[1] = 32'(b1.VEC);
  assign ovec[2] = 32'(b2.VEC);
  assign oerr[0] = 32'(b0.ERRCNT);
  assign oerr[1] = 32'(b1.ERRCNT);
  assign oerr[2] = 32'(b2.ERRCNT);
  assign ofe[0] = 32'(b0.FIRSTERR);
  assign ofe[1] = 32'(b1.FIRSTERR);
  assign ofe[2] = 32'(b2.FIRSTERR);
  assign obusy[0] = b0.BUSY;
  assign obusy[1] = b1.BUSY;
  assign obusy[2] = b2.BUSY;
  assign odone[0] = b0.DONE;
  assign odone[1] = b1.DONE;
  assign odone[2] = b2.DONE;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, a, e);
    end
  endtask

  // one clock edge: capture inputs, advance the run model, compare all three DUTs
  task automatic step();
    logic ys [3];
    logic ss [3];
    logic [15:0] ts [3];
    logic rs;
    int v;
    int p;
    for (int d = 0; d < 3; d++) begin
      ys[d] = yv[d];
      ss[d] = st[d];
      ts[d] = tt[d];
    end
    rs = R;
    @(posedge CLK);
    #1;
    for (int d = 0; d < 3; d++) begin
      p = SS[d] + 1;
      if (!rs) begin
        m_act[d] = 0; m_done[d] = 0; m_k[d] = 0; m_tt[d] = '0; m_err[d] = 0; m_first[d] = 0;
      end else begin
        m_done[d] = 0;
        if (!m_act[d]) begin
          if (ss[d]) begin
            m_act[d] = 1; m_k[d] = 0; m_tt[d] = ts[d]; m_err[d] = 0; m_first[d] = 0;
          end
        end else begin
          m_k[d]++;
          if (m_k[d] % p == 0) begin
            v = m_k[d] / p - 1;
            if (ys[d] !== m_tt[d][v]) begin
              if (m_err[d] == 0) m_first[d] = v;
              m_err[d]++;
            end
            if (v == (1 << NN[d]) - 1) begin
              m_act[d] = 0;
              m_done[d] = 1;
            end
          end
        end
      end
      chk($sformatf("d%0d_vec", d), ovec[d], m_act[d] ? 32'(m_k[d] / p) : 32'd0);
      chk($sformatf("d%0d_busy", d), 32'(obusy[d]), 32'(m_act[d]));
      chk($sformatf("d%0d_done", d), 32'(odone[d]), 32'(m_done[d]));
      chk($sformatf("d%0d_errcnt", d), oerr[d], 32'(m_err[d]));
      chk($sformatf("d%0d_firsterr", d), ofe[d], 32'(m_first[d]));
    end
  endtask

  task automatic run(input int d, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!odone[d] && n < 200);
    chk($sformatf("d%0d_done_timeout", d), 32'(odone[d]), 32'd1);
  endtask

  task automatic launch(input int d, input logic [15:0] t, output int n);
    tt[d] = t;
    st[d] = 1'b1;
    step();
    st[d] = 1'b0;
    run(d, n);
  endtask

  initial begin
    int n;
    int pulses;
    for (int d = 0; d < 3; d++) begin
      st[d] = 1'b0;
      tt[d] = '0;
    end
    R = 1'b0;
    step();
    step();
    chk("rst_vec", ovec[0], 32'd0);
    chk("rst_busy", 32'(obusy[0]), 32'd0);
    chk("rst_done", 32'(odone[0]), 32'd0);
    chk("rst_errcnt", oerr[0], 32'd0);
    chk("rst_firsterr", ofe[0], 32'd0);
    R = 1'b1;
    step();
    launch(0, 16'h7, n);
    chk("nand_edges", 32'(n), 32'd8);
    chk("nand_errcnt", oerr[0], 32'd0);
    chk("nand_busy_at_done", 32'(obusy[0]), 32'd0);
    step();
    xor_mode = 1'b1;
    launch(0, 16'h9, n);
    chk("xnor_errcnt", oerr[0], 32'd4);
    chk("xnor_firsterr", ofe[0], 32'd0);
    xor_mode = 1'b0;
    step();
    launch(1, 16'h07, n);
    chk("aoi_edges", 32'(n), 32'd8);
    chk("aoi_errcnt", oerr[1], 32'd0);
    launch(1, 16'h0f, n);
    chk("aoi_bad_errcnt", oerr[1], 32'd1);
    chk("aoi_bad_firsterr", ofe[1], 32'd3);
    tt[0] = 16'h7;
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    R = 1'b0;
    step();
    R = 1'b1;
    chk("abort_vec", ovec[0], 32'd0);
    chk("abort_busy", 32'(obusy[0]), 32'd0);
    chk("abort_done", 32'(odone[0]), 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (odone[0]) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    launch(0, 16'h7, n);
    chk("rerun_edges", 32'(n), 32'd8);
    chk("rerun_errcnt", oerr[0], 32'd0);
    pulses = 0;
    st[2] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tt[2] = (i >= 2 && i < 4) ? 16'h2 : 16'h1;
      step();
      if (odone[2]) pulses++;
    end
    chk("b2b_pulses", 32'(pulses), 32'd3);
    st[2] = 1'b0;
    run(2, n);
    chk("b2b_errcnt", oerr[2], 32'd0);
    x_en = 1'b1;
    launch(0, 16'h7, n);
    x_en = 1'b0;
    chk("xrun_edges", 32'(n), 32'd8);
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
